wdt_servicer: RTL and testbench
===============================

Name: wdt_servicer

Overview:
Host-side partner of the watchdog timer. It drives the watchdog's programming and service interface (ld_en, ld_cnt, en, kick) and consumes its early-warning output rst_int. It kicks the watchdog periodically only while a monitored task shows a live heartbeat. When the heartbeat stops, it stops kicking on purpose so that the watchdog fires rst_sys.

Parameters:
CNT_W, 24, width of ld_cnt; matches the watchdog's load-count width.
LOAD_VAL, 8, timeout value programmed into the watchdog; driven constantly on ld_cnt.
KICK_PERIOD, 4, cycles from the start of one kick to the start of the next; must be >= 2 and < LOAD_VAL.
KICK_LEN, 2, width of each kick pulse in cycles; must be >= 1 and < KICK_PERIOD.
HB_TIMEOUT, 16, maximum cycles allowed between heartbeat pulses; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  level; high = service the watchdog, low = disable it
heartbeat  in  1  single-cycle pulse from the monitored task
rst_int  in  1  early-warning interrupt from the watchdog
ld_en  out  1  load strobe to the watchdog
ld_cnt  out  CNT_W  load value to the watchdog; always LOAD_VAL
en  out  1  watchdog enable
kick  out  1  watchdog service pulse
hb_lost  out  1  sticky flag: heartbeat timeout occurred
warn_cnt  out  8  saturating count of rst_int rising edges

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: ld_en=0, en=0, kick=0, hb_lost=0, warn_cnt=0, ld_cnt=LOAD_VAL; state=IDLE; all internal counters=0.
- Reset asserted mid-operation (any state) forces the reset values on the next edge and has priority over every other input.
- FSM states: IDLE, LOAD, ARM, RUN, STARVE.
- IDLE: en=0, kick=0. If start=1, go to LOAD.
- LOAD: ld_en=1 for exactly 2 cycles, en=0, then go to ARM.
- ARM: ld_en=0, en=1 for 1 cycle. hb_cnt and kick_cnt clear to 0. Go to RUN.
- RUN: en=1.
  - kick_cnt counts 0..KICK_PERIOD-1 and wraps.
  - kick=1 in RUN cycles where kick_cnt >= KICK_PERIOD-KICK_LEN.
  - With defaults, kick is high in RUN cycles 2,3,6,7,... (cycle 0 = first RUN cycle).
  - hb_cnt clears to 0 on heartbeat=1, otherwise increments.
  - When hb_cnt reaches HB_TIMEOUT-1 with no heartbeat that cycle, go to STARVE.
- STARVE: en=1, kick=0, hb_lost=1. The watchdog then expires on its own. Exits only on rst, or on start=0 (to IDLE).
- start=0 in LOAD, ARM, RUN or STARVE: go to IDLE next cycle, with en=0 and kick=0 there.
- hb_lost is sticky until rst. Returning to IDLE via start=0 does not clear it.
- Simultaneous events:
  - heartbeat in the same cycle as the timeout condition: heartbeat wins and RUN continues.
  - start=0 in the same cycle as the timeout: IDLE wins, but hb_lost is still set.
- A kick pulse in progress when STARVE or IDLE is entered is truncated immediately; kick=0 on the next cycle.
- heartbeat in IDLE, LOAD or ARM is ignored.
- warn_cnt increments on each 0->1 transition of rst_int (tracked with a 1-cycle delayed copy) in any state. It saturates at 255 and is cleared only by rst.
- Counter widths are clog2 of the respective parameter. Overflow is impossible given the parameter constraints.

Decomposition:
- Shared package wdt_pkg holds:
  - the state encoding typedef (IDLE=0, LOAD=1, ARM=2, RUN=3, STARVE=4, 3 bits);
  - WDT_CNT_W=24;
  - the default LOAD_VAL.
- The watchdog block and this servicer both import wdt_pkg.
- One sub-module is natural: wdt_edge_cnt, a rising-edge detector plus saturating 8-bit counter, used for warn_cnt.

Test Plan:
- Reset then start=1 -> ld_en high for 2 cycles with ld_cnt=8, then en=1 from the ARM cycle onward, kick=0 until RUN cycle 2.
- RUN with heartbeat every 10 cycles for 100 cycles, defaults -> kick high at RUN cycles 2,3,6,7,... every 4 cycles; hb_lost=0; the attached watchdog never asserts rst_sys.
- Heartbeat stops after RUN cycle 20 -> STARVE 16 cycles after the last heartbeat; kick=0 from then on; hb_lost=1; the watchdog asserts rst_int, then rst_sys, within 8 cycles; warn_cnt=1.
- Heartbeat in the exact cycle hb_cnt=15 -> remains in RUN, hb_lost=0, kick cadence uninterrupted.
- start=0 during a kick pulse in RUN -> next cycle en=0 and kick=0, state IDLE; start=1 again -> LOAD repeats with 2 ld_en cycles.
- rst=1 for 1 cycle in STARVE with 300 rst_int edges seen -> warn_cnt was 255 (saturated) before reset; all outputs return to reset values; hb_lost=0.

Source files
------------

// File: rtl/wdt_pkg.sv
// Shared definitions for the watchdog timer and its host-side servicer.
// Holds the state encoding, the load-count width and the default timeout value.
package wdt_pkg;

  localparam int unsigned WDT_CNT_W    = 24;
  localparam int unsigned WDT_LOAD_VAL = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLoad   = 3'd1,
    StArm    = 3'd2,
    StRun    = 3'd3,
    StStarve = 3'd4
  } wdt_state_e;

  // True in the trailing KICK_LEN cycles of each KICK_PERIOD-long service window.
  function automatic logic kick_window(input int unsigned cnt, input int unsigned period,
                                       input int unsigned len);
    return cnt >= (period - len);
  endfunction

endpackage

// File: rtl/wdt_edge_cnt.sv
// Rising-edge detector feeding a saturating counter.
// Counts 0->1 transitions of din; holds at all-ones until reset.
module wdt_edge_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  output logic [CNT_W-1:0] count
);

  logic             din_q;
  logic             rise;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  assign rise = din & ~din_q;

  always_comb begin
    count_d = count_q;
    if (rise && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q   <= 1'b0;
      count_q <= '0;
    end else begin
      din_q   <= din;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/wdt_servicer.sv
// Host-side watchdog servicer: programs the watchdog, kicks it while a monitored
// task shows a heartbeat, and deliberately stops kicking once the heartbeat is lost.
module wdt_servicer
  import wdt_pkg::*;
#(
  parameter int unsigned CNT_W       = WDT_CNT_W,
  parameter int unsigned LOAD_VAL    = WDT_LOAD_VAL,
  parameter int unsigned KICK_PERIOD = 4,
  parameter int unsigned KICK_LEN    = 2,
  parameter int unsigned HB_TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             heartbeat,
  input  logic             rst_int,
  output logic             ld_en,
  output logic [CNT_W-1:0] ld_cnt,
  output logic             en,
  output logic             kick,
  output logic             hb_lost,
  output logic [7:0]       warn_cnt
);

  localparam int unsigned KW = (KICK_PERIOD > 1) ? $clog2(KICK_PERIOD) : 1;
  localparam int unsigned HW = (HB_TIMEOUT > 1) ? $clog2(HB_TIMEOUT) : 1;

  localparam logic [KW-1:0] KICK_LAST = KW'(KICK_PERIOD - 1);
  localparam logic [HW-1:0] HB_LAST   = HW'(HB_TIMEOUT - 1);

  wdt_state_e state_d, state_q;

  logic          load_cnt_d, load_cnt_q;
  logic [KW-1:0] kick_cnt_d, kick_cnt_q;
  logic [HW-1:0] hb_cnt_d, hb_cnt_q;
  logic          hb_lost_d, hb_lost_q;
  logic          timeout;

  logic             ld_en_d, en_d, kick_d;
  logic             ld_en_q, en_q, kick_q;
  logic [CNT_W-1:0] ld_cnt_q;

  // A heartbeat in the final allowed cycle rescues the task.
  assign timeout = (state_q == StRun) && (hb_cnt_q == HB_LAST) && !heartbeat;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = 1'b0;
    kick_cnt_d = kick_cnt_q;
    hb_cnt_d   = hb_cnt_q;
    hb_lost_d  = hb_lost_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (!start) begin
          state_d = StIdle;
        end else if (load_cnt_q) begin
          state_d = StArm;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      StArm: begin
        kick_cnt_d = '0;
        hb_cnt_d   = '0;
        state_d    = start ? StRun : StIdle;
      end
      StRun: begin
        kick_cnt_d = (kick_cnt_q == KICK_LAST) ? '0 : kick_cnt_q + 1'b1;
        hb_cnt_d   = heartbeat ? '0 : hb_cnt_q + 1'b1;
        // The loss is recorded even when start=0 sends us to idle instead.
        if (timeout) begin
          hb_lost_d = 1'b1;
        end
        if (!start) begin
          state_d = StIdle;
        end else if (timeout) begin
          state_d = StStarve;
        end
      end
      StStarve: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe;
  // a kick in flight drops as soon as RUN is left.
  always_comb begin
    ld_en_d = (state_d == StLoad);
    en_d    = (state_d == StArm) || (state_d == StRun) || (state_d == StStarve);
    kick_d  = (state_d == StRun) && kick_window(32'(kick_cnt_d), KICK_PERIOD, KICK_LEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      load_cnt_q <= 1'b0;
      kick_cnt_q <= '0;
      hb_cnt_q   <= '0;
      hb_lost_q  <= 1'b0;
      ld_en_q    <= 1'b0;
      en_q       <= 1'b0;
      kick_q     <= 1'b0;
      ld_cnt_q   <= CNT_W'(LOAD_VAL);
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      kick_cnt_q <= kick_cnt_d;
      hb_cnt_q   <= hb_cnt_d;
      hb_lost_q  <= hb_lost_d;
      ld_en_q    <= ld_en_d;
      en_q       <= en_d;
      kick_q     <= kick_d;
      ld_cnt_q   <= CNT_W'(LOAD_VAL);
    end
  end

  wdt_edge_cnt #(
    .CNT_W (8)
  ) u_warn_cnt (
    .clk   (clk),
    .rst   (rst),
    .din   (rst_int),
    .count (warn_cnt)
  );

  assign ld_en   = ld_en_q;
  assign ld_cnt  = ld_cnt_q;
  assign en      = en_q;
  assign kick    = kick_q;
  assign hb_lost = hb_lost_q;

endmodule

// File: tb/tb_wdt_servicer.sv
// Bench for wdt_servicer: a per-cycle vector table plus directed sequences, with a
// small watchdog model closing the loop on ld_en/en/kick and producing rst_int.
module tb_wdt_servicer;

  localparam int unsigned LOAD_VAL = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        heartbeat = 1'b0;
  logic        rst_int;
  logic        ld_en;
  logic [23:0] ld_cnt;
  logic        en;
  logic        kick;
  logic        hb_lost;
  logic [7:0]  warn_cnt;

  int checks = 0;
  int errors = 0;

  // Watchdog model: loads on ld_en, reloads on kick, counts down while enabled.
  logic [23:0] wd_cnt;
  logic        wd_int;
  logic        rst_sys;
  logic        rst_sys_seen;
  logic        force_int = 1'b0;
  logic        forced_val = 1'b0;

  assign wd_int  = en && (wd_cnt <= 24'd4);
  assign rst_sys = en && (wd_cnt == 24'd0);
  assign rst_int = force_int ? forced_val : wd_int;

  always @(posedge clk) begin
    if (rst) begin
      wd_cnt       <= '0;
      rst_sys_seen <= 1'b0;
    end else begin
      if (ld_en) wd_cnt <= ld_cnt;
      else if (en && kick) wd_cnt <= 24'(LOAD_VAL);
      else if (en && (wd_cnt != 0)) wd_cnt <= wd_cnt - 1'b1;
      if (rst_sys) rst_sys_seen <= 1'b1;
    end
  end

  always #5 clk = ~clk;

  wdt_servicer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .heartbeat (heartbeat),
    .rst_int   (rst_int),
    .ld_en     (ld_en),
    .ld_cnt    (ld_cnt),
    .en        (en),
    .kick      (kick),
    .hb_lost   (hb_lost),
    .warn_cnt  (warn_cnt)
  );

  typedef struct packed {
    logic start;
    logic hb;
    logic ld_en;
    logic en;
    logic kick;
    logic hb_lost;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    heartbeat = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // LOAD, LOAD, ARM, then the first RUN cycle.
  task automatic enter_run();
    start = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int m;
    logic saw_int;
    logic saw_kick;
    logic lost_early;

    //             start hb ld_en en kick lost
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // LOAD
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};  // LOAD (hb ignored)
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // ARM
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN0
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN1
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};  // RUN2
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};  // RUN3
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN4
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN5
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};  // RUN6, kick in flight
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // IDLE, kick truncated
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // IDLE
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // LOAD again
    vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};  // LOAD
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // ARM
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN0
    vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // RUN1

    // Reset values
    do_reset();
    check("rst_ld_en", 32'(ld_en), 32'd0);
    check("rst_en", 32'(en), 32'd0);
    check("rst_kick", 32'(kick), 32'd0);
    check("rst_hb_lost", 32'(hb_lost), 32'd0);
    check("rst_warn_cnt", 32'(warn_cnt), 32'd0);
    check("rst_ld_cnt", 32'(ld_cnt), 32'(LOAD_VAL));

    // Vector table: inputs are sampled on the next edge, outputs checked after it
    for (int i = 0; i < 17; i++) begin
      start = vecs[i].start;
      heartbeat = vecs[i].hb;
      tick();
      heartbeat = 1'b0;
      check($sformatf("vec%0d_ld_en", i), 32'(ld_en), 32'(vecs[i].ld_en));
      check($sformatf("vec%0d_en", i), 32'(en), 32'(vecs[i].en));
      check($sformatf("vec%0d_kick", i), 32'(kick), 32'(vecs[i].kick));
      check($sformatf("vec%0d_hb_lost", i), 32'(hb_lost), 32'(vecs[i].hb_lost));
      check($sformatf("vec%0d_ld_cnt", i), 32'(ld_cnt), 32'(LOAD_VAL));
    end

    // Healthy run: heartbeat every 10 cycles for 100 RUN cycles
    do_reset();
    enter_run();
    for (int k = 0; k < 100; k++) begin
      check($sformatf("healthy_kick_%0d", k), 32'(kick), 32'((k % 4) >= 2));
      check($sformatf("healthy_lost_%0d", k), 32'(hb_lost), 32'd0);
      heartbeat = ((k % 10) == 9);
      tick();
      heartbeat = 1'b0;
    end
    check("healthy_no_rst_sys", 32'(rst_sys_seen), 32'd0);
    check("healthy_warn_cnt", 32'(warn_cnt), 32'd0);

    // Heartbeat stops: last one sampled in RUN19, STARVE 16 cycles on
    do_reset();
    enter_run();
    for (int k = 0; k < 20; k++) begin
      heartbeat = ((k % 10) == 9);
      tick();
      heartbeat = 1'b0;
    end
    n = 0;
    while (!hb_lost && n < 40) begin
      tick();
      n++;
    end
    check("starve_entry_delay", 32'(n), 32'd16);
    check("starve_kick", 32'(kick), 32'd0);
    check("starve_en", 32'(en), 32'd1);
    m = 0;
    saw_int = 1'b0;
    saw_kick = 1'b0;
    while (!rst_sys && m < 12) begin
      if (rst_int) saw_int = 1'b1;
      if (kick) saw_kick = 1'b1;
      tick();
      m++;
    end
    check("starve_rst_sys_within_8", 32'((m >= 1) && (m <= 8)), 32'd1);
    check("starve_rst_int_before_sys", 32'(saw_int), 32'd1);
    check("starve_no_kick", 32'(saw_kick), 32'd0);
    tick();
    tick();
    check("starve_warn_cnt", 32'(warn_cnt), 32'd1);
    start = 1'b0;
    tick();
    check("starve_exit_en", 32'(en), 32'd0);
    check("starve_exit_kick", 32'(kick), 32'd0);
    check("starve_exit_lost_sticky", 32'(hb_lost), 32'd1);

    // Heartbeat exactly when hb_cnt = 15 keeps RUN alive
    do_reset();
    enter_run();
    lost_early = 1'b0;
    for (int k = 0; k < 31; k++) begin
      check($sformatf("rescue_kick_%0d", k), 32'(kick), 32'((k % 4) >= 2));
      if (hb_lost) lost_early = 1'b1;
      heartbeat = (k == 15) || (k == 25);
      tick();
      heartbeat = 1'b0;
    end
    check("rescue_hb_lost", 32'(lost_early | hb_lost), 32'd0);
    check("rescue_en", 32'(en), 32'd1);

    // start=0 in the timeout cycle: IDLE wins, loss still recorded
    do_reset();
    enter_run();
    repeat (15) tick();
    start = 1'b0;
    tick();
    check("tie_en", 32'(en), 32'd0);
    check("tie_kick", 32'(kick), 32'd0);
    check("tie_hb_lost", 32'(hb_lost), 32'd1);
    start = 1'b1;
    tick();
    check("tie_reload_ld_en", 32'(ld_en), 32'd1);
    check("tie_reload_lost", 32'(hb_lost), 32'd1);

    // Saturate warn_cnt in STARVE, then reset mid-operation
    do_reset();
    enter_run();
    n = 0;
    while (!hb_lost && n < 30) begin
      tick();
      n++;
    end
    check("sat_reached_starve", 32'(hb_lost), 32'd1);
    force_int = 1'b1;
    forced_val = 1'b0;
    tick();
    for (int i = 0; i < 300; i++) begin
      forced_val = 1'b1;
      tick();
      forced_val = 1'b0;
      tick();
    end
    check("sat_warn_cnt", 32'(warn_cnt), 32'd255);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    force_int = 1'b0;
    check("sat_rst_ld_en", 32'(ld_en), 32'd0);
    check("sat_rst_en", 32'(en), 32'd0);
    check("sat_rst_kick", 32'(kick), 32'd0);
    check("sat_rst_hb_lost", 32'(hb_lost), 32'd0);
    check("sat_rst_warn_cnt", 32'(warn_cnt), 32'd0);
    check("sat_rst_ld_cnt", 32'(ld_cnt), 32'(LOAD_VAL));
    tick();
    check("sat_restart_ld_en", 32'(ld_en), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
